// File: rtl/spi_main.sv
// spi_main: SPI mode-0 master, one full-duplex WIDTH-bit frame per start edge.
// MSB-first on mosi; miso is captured into the rx shift register and published
// on rx only once the whole frame has been received.
module spi_main #(
    parameter int unsigned WIDTH       = 128,
    parameter int unsigned HALF_PERIOD = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] tx,
    input  logic             miso,
    output logic [WIDTH-1:0] rx,
    output logic             cs_n,
    output logic             sclk,
    output logic             mosi,
    output logic             done
);

    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam int unsigned DW = $clog2(HALF_PERIOD + 1);

    typedef enum logic [1:0] {
        StIdle,
        StXfer,
        StFinish
    } state_t;

    state_t           state;
    logic             start_q;
    logic [WIDTH-1:0] tx_sr;
    logic [WIDTH-1:0] rx_sr;
    logic [CW-1:0]    bit_cnt;
    logic [DW-1:0]    div_cnt;

    // Single FSM: start-edge detect, sclk divider, shift registers and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= StIdle;
            start_q <= 1'b0;
            tx_sr   <= '0;
            rx_sr   <= '0;
            bit_cnt <= '0;
            div_cnt <= '0;
            rx      <= '0;
            cs_n    <= 1'b1;
            sclk    <= 1'b0;
            mosi    <= 1'b0;
            done    <= 1'b0;
        end else begin
            start_q <= start;
            case (state)
                StIdle: begin
                    cs_n <= 1'b1;
                    sclk <= 1'b0;
                    mosi <= 1'b0;
                    done <= 1'b0;
                    // Only a 0->1 transition starts a frame; a held level does not retrigger.
                    if (start && !start_q) begin
                        tx_sr   <= tx;
                        rx_sr   <= '0;
                        cs_n    <= 1'b0;
                        mosi    <= tx[WIDTH-1];
                        bit_cnt <= '0;
                        div_cnt <= '0;
                        state   <= StXfer;
                    end
                end
                StXfer: begin
                    if (div_cnt == DW'(HALF_PERIOD - 1)) begin
                        div_cnt <= '0;
                        if (!sclk) begin
                            // Rising edge: sample the sub's bit.
                            sclk  <= 1'b1;
                            rx_sr <= {rx_sr[WIDTH-2:0], miso};
                        end else begin
                            // Falling edge: present the next bit while sclk is low.
                            sclk  <= 1'b0;
                            tx_sr <= {tx_sr[WIDTH-2:0], 1'b0};
                            mosi  <= tx_sr[WIDTH-2];
                            if (bit_cnt == CW'(WIDTH - 1)) begin
                                state <= StFinish;
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                StFinish: begin
                    cs_n  <= 1'b1;
                    mosi  <= 1'b0;
                    rx    <= rx_sr;
                    done  <= 1'b1;
                    state <= StIdle;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_main.sv
// Directed bench for spi_main with a behavioural spi_sub link partner.
module tb_spi_main;

    logic         clk;
    logic         rst;
    logic         start;
    logic [127:0] tx;
    logic         miso;
    logic [127:0] rx;
    logic         cs_n;
    logic         sclk;
    logic         mosi;
    logic         done;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;

    // Behavioural sub state.
    logic [127:0] sub_tx = '0;
    logic [127:0] sub_sr = '0;
    logic [127:0] sub_rx_sr = '0;
    logic [127:0] sub_rx = '0;
    int           sub_cnt = 0;

    spi_main #(
        .WIDTH      (128),
        .HALF_PERIOD(1)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .tx   (tx),
        .miso (miso),
        .rx   (rx),
        .cs_n (cs_n),
        .sclk (sclk),
        .mosi (mosi),
        .done (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Sub model: load while deselected, sample on sclk rise, shift on sclk fall.
    always @(cs_n or sub_tx) begin
        if (cs_n === 1'b1) begin
            sub_sr  = sub_tx;
            sub_cnt = 0;
        end
    end
    always @(posedge sclk) begin
        if (cs_n === 1'b0) begin
            sub_rx_sr = {sub_rx_sr[126:0], mosi};
            sub_cnt   = sub_cnt + 1;
            if (sub_cnt == 128) sub_rx = sub_rx_sr;
        end
    end
    always @(negedge sclk) begin
        if (cs_n === 1'b0) sub_sr = {sub_sr[126:0], 1'b0};
    end
    assign miso = sub_sr[127];

    always @(negedge clk) if (done === 1'b1) done_cnt++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, got, exp);
        end
    endtask

    // Runs one frame from a start edge; start is held for 'hold' cycles (< 250).
    task automatic frame(input string tag, input logic [127:0] mtx, input logic [127:0] stx,
                         input int hold);
        int lat;
        int d0;
        bit sclk_bad;
        bit cs_bad;
        bit mosi_bad;
        int i;
        lat      = -1;
        sclk_bad = 0;
        cs_bad   = 0;
        mosi_bad = 0;
        d0       = done_cnt;
        tx       = mtx;
        sub_tx   = stx;
        start    = 1'b1;
        tick();
        chk({tag, "_cs_at_start"}, 128'(cs_n), 128'(0));
        chk({tag, "_mosi_at_start"}, 128'(mosi), 128'(mtx[127]));
        for (int k = 1; k <= 400; k++) begin
            if (k == hold) start = 1'b0;
            tick();
            if (k <= 256) begin
                if (sclk !== 1'(k % 2)) sclk_bad = 1;
                if (cs_n !== 1'b0) cs_bad = 1;
                if (k % 2 == 0) begin
                    i = (k - 2) / 2;
                    if (mosi !== ((i < 127) ? mtx[126 - i] : 1'b0)) mosi_bad = 1;
                end
            end
            if (done === 1'b1 && lat < 0) lat = k;
            if (lat > 0 && k == lat + 1) begin
                chk({tag, "_done_one_cycle"}, 128'(done), 128'(0));
                break;
            end
        end
        chk({tag, "_latency"}, 128'(lat), 128'(257));
        chk({tag, "_sclk_pattern"}, 128'(sclk_bad), 128'(0));
        chk({tag, "_cs_low"}, 128'(cs_bad), 128'(0));
        chk({tag, "_mosi_bits"}, 128'(mosi_bad), 128'(0));
        chk({tag, "_cs_idle"}, 128'(cs_n), 128'(1));
        chk({tag, "_rx"}, rx, stx);
        chk({tag, "_sub_rx"}, sub_rx, mtx);
        chk({tag, "_done_count"}, 128'(done_cnt - d0), 128'(1));
    endtask

    initial begin
        int d0;
        rst   = 1'b1;
        start = 1'b0;
        tx    = '0;
        repeat (3) tick();
        chk("rst_cs_n", 128'(cs_n), 128'(1));
        chk("rst_sclk", 128'(sclk), 128'(0));
        chk("rst_mosi", 128'(mosi), 128'(0));
        chk("rst_done", 128'(done), 128'(0));
        chk("rst_rx", rx, 128'(0));
        rst = 1'b0;
        tick();

        // Frame 1: start pulsed for 10 cycles.
        frame("f1", 128'h00112233445566778899aabbccddeeff, 128'h0, 10);
        repeat (3) tick();
        chk("f1_rx_hold", rx, 128'h0);

        frame("f2", 128'h99999999999999999, 128'h555555555555555555, 1);
        chk("f2_rx_literal", rx, 128'h00000000000000555555555555555555);
        chk("f2_sub_literal", sub_rx, 128'h00000000000000099999999999999999);
        repeat (2) tick();

        frame("f3", 128'habde1, 128'hfa4d, 1);
        repeat (5) tick();
        chk("f3_rx_hold", rx, 128'hfa4d);

        // Second start edge while busy is ignored.
        d0     = done_cnt;
        tx     = 128'hdeadbeef_01234567_89abcdef_cafef00d;
        sub_tx = 128'h0f0f0f0f_12345678_a5a5a5a5_77777777;
        start  = 1'b1;
        tick();
        start = 1'b0;
        repeat (100) tick();
        start = 1'b1;
        repeat (5) tick();
        start = 1'b0;
        repeat (500) tick();
        chk("busy_edge_done_count", 128'(done_cnt - d0), 128'(1));
        chk("busy_edge_rx", rx, 128'h0f0f0f0f_12345678_a5a5a5a5_77777777);
        chk("busy_edge_sub_rx", sub_rx, 128'hdeadbeef_01234567_89abcdef_cafef00d);

        // Held level yields exactly one frame.
        d0     = done_cnt;
        tx     = 128'h1;
        sub_tx = 128'h8000_0000_0000_0000_0000_0000_0000_0003;
        start  = 1'b1;
        repeat (600) tick();
        chk("held_cs_idle", 128'(cs_n), 128'(1));
        start = 1'b0;
        repeat (5) tick();
        chk("held_done_count", 128'(done_cnt - d0), 128'(1));
        chk("held_rx", rx, 128'h8000_0000_0000_0000_0000_0000_0000_0003);

        // Reset at bit 60 (sclk rise at N+121).
        d0     = done_cnt;
        tx     = 128'hffff_ffff_ffff_ffff_ffff_ffff_ffff_ffff;
        sub_tx = 128'h1234;
        start  = 1'b1;
        tick();
        start = 1'b0;
        repeat (120) tick();
        rst = 1'b1;
        tick();
        chk("abort_cs_n", 128'(cs_n), 128'(1));
        chk("abort_sclk", 128'(sclk), 128'(0));
        chk("abort_mosi", 128'(mosi), 128'(0));
        chk("abort_rx", rx, 128'h0);
        chk("abort_done", 128'(done), 128'(0));
        rst = 1'b0;
        repeat (300) tick();
        chk("abort_no_done", 128'(done_cnt - d0), 128'(0));
        chk("abort_rx_still_zero", rx, 128'h0);

        frame("post", 128'hfedcba98_76543210_0badc0de_13579bdf, 128'h2468ace0_11223344_55667788_99aabbcc, 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_main.md
# spi_main

SPI master that performs one full-duplex 128-bit transfer per start request, shifting out `tx` MSB-first while capturing `miso` into `rx`. It is the host-side end of the AES SPI link. The companion `spi_sub` receives the 128-bit block for the AES core and returns its result on the same frame. `spi_sub` is clocked by `sclk`/`cs` and is specified here only as the link partner this block must interoperate with.

## Interface
Parameters:
- `WIDTH`, 128: frame length in bits.
- `HALF_PERIOD`, 1: `clk` cycles per `sclk` half-period. All cycle numbers below use this default.

Ports:
- One clock; reset is synchronous and active-high.
- `clk`  in  1  system clock; all logic on its rising edge.
- `rst`  in  1  synchronous active-high reset.
- `start`  in  1  transfer request; may be held high for many cycles.
- `tx`  in  128  word to send, sampled when the transfer starts.
- `miso`  in  1  serial data from the sub.
- `rx`  out  128  last fully received word.
- `cs_n`  out  1  chip select, active low.
- `sclk`  out  1  serial clock, idle low.
- `mosi`  out  1  serial data to the sub.
- `done`  out  1  one-cycle completion pulse.

Partner `spi_sub` ports: `cs`, `sclk`, `sdi`, `tx[127:0]`, `rx[127:0]`, `sdo`, `done`.

## Operation
- SPI mode 0:
  - CPOL=0, CPHA=0, MSB first.
  - Data is driven while `sclk` is low and sampled on the `sclk` rising edge.
- States: IDLE, XFER, FINISH.
- IDLE:
  - `cs_n`=1, `sclk`=0, `mosi`=0, `done`=0.
  - `rx` holds its previous value.
- Start:
  - A transfer starts on a rising edge of `start` (registered previous value low, current high) while in IDLE.
  - A level held high does not retrigger.
  - `start` edges outside IDLE are ignored.
- Start action:
  - Load the tx shift register from `tx`.
  - Drive `cs_n`=0 and `mosi`=`tx[127]`.
  - Clear the bit counter and enter XFER.
- XFER, per bit i=0..127:
  - Raise `sclk` and shift `miso` into the LSB of the rx shift register.
  - Then lower `sclk` and drive the next tx bit on `mosi`.
  - After the 128th falling edge, go to FINISH.
- FINISH:
  - `cs_n`=1 and `mosi`=0.
  - `rx` loads the full rx shift register (first received bit lands in `rx[127]`).
  - `done`=1 for exactly one cycle, then IDLE.
- `rx` changes only in FINISH and on reset; partial data never appears on `rx`.
- Reset (any state, including mid-frame):
  - Next state IDLE; `cs_n`=1, `sclk`=0, `mosi`=0, `done`=0, `rx`=0.
  - Shift registers, counter and start-edge register all cleared.
  - An aborted frame produces no `done`.
- Partner `spi_sub` behaviour:
  - While `cs` is high it loads `tx` into its shift register and presents `tx[127]` on `sdo`.
  - On `sclk` rising it samples `sdi`; on `sclk` falling it shifts out the next bit.
  - After 128 bits it updates `rx` and raises `done` until `cs` returns high.

## Timing
- Start sampled at edge N (`start` 0 then 1, state IDLE): at N, `cs_n`=0 and `mosi`=`tx[127]`.
- Bit i:
  - `sclk` rises at N+1+2i, where `miso` is sampled.
  - `sclk` falls at N+2+2i, where `mosi` gets bit 126−i.
  - i=0..127.
- The last falling edge of `sclk` is at N+256.
- At N+257: `cs_n`=1, `rx` is valid, `done`=1.
- At N+258: `done`=0, state IDLE. The earliest next start edge is sampled at N+258.
- `sclk` period is 2 `clk` cycles; a full frame is 258 cycles including setup and finish.
- `cs_n` stays low continuously from N through N+256.

## Test plan
- After reset: `cs_n`=1, `sclk`=0, `mosi`=0, `done`=0, `rx`=0.
- Frame 1:
  - Stimulus: `tx`=00112233445566778899aabbccddeeff, sub `tx`=0, `start` pulsed high for 10 cycles.
  - Required: exactly one frame; `done` pulse 257 cycles after the start edge; `rx`=0; sub `rx`=00112233445566778899aabbccddeeff.
- Frame 2:
  - Stimulus: `tx`=128'h99999999999999999, sub `tx`=128'h555555555555555555.
  - Required: master `rx`=00000000000000555555555555555555; sub `rx`=00000000000000099999999999999999.
- Frame 3:
  - Stimulus: `tx`=128'habde1, sub `tx`=128'hfa4d.
  - Required: master `rx`=...0fa4d; sub `rx`=...abde1.
- Edge-only start:
  - Stimulus: a second `start` edge during XFER; separately, `start` held high for 600 cycles.
  - Required: the busy-time edge is ignored; the held level yields exactly one frame and one `done`.
- Reset mid-frame:
  - Stimulus: `rst` at bit 60.
  - Required: the next cycle shows `cs_n`=1, `sclk`=0, `rx`=0, no `done`.
  - A following start then completes a normal frame.
